grey_to_binary_sync: RTL and testbench
======================================

// Module: grey_to_binary_sync
// PURPOSE
//  Receive-side partner of the binary-to-grey encoder on the timestamp path. Takes a
//  grey-coded counter bus launched from a foreign clock domain, synchronises it into clk,
//  rejects samples where more than one bit changed, and decodes valid samples to binary.
//  Feeds the local timestamp compare logic with a monotonic, glitch-free binary count.
// PARAMETERS
//  WIDTH        32  bus width of grey input and binary output (>= 2)
//  SYNC_STAGES  2   flip-flop synchroniser depth per bit (>= 2)
// PORTS
//  clk            in   1      single clock; all logic on rising edge
//  reset          in   1      synchronous, active-high reset
//  in_grey        in   WIDTH  grey-coded count from the foreign domain (asynchronous to clk)
//  clr_err        in   1      single-cycle pulse; clears err_count
//  out_binary     out  WIDTH  decoded binary count, held between updates
//  out_valid      out  1      high once the first sample has been accepted after reset
//  out_changed    out  1      one-cycle pulse when out_binary loads a new value
//  err_multibit   out  1      one-cycle pulse when a sample with >1 changed bit is rejected
//  err_count      out  16     saturating count of rejected samples
// BEHAVIOUR
//  - Reset: sync chain, g_prev, out_binary, err_count = 0; out_valid, out_changed,
//    err_multibit = 0; FSM -> FLUSH. Reset asserted mid-operation discards all state.
//  - Sync: per-bit SYNC_STAGES-deep FF chain; g_s = last stage. g_prev registers g_s
//    every cycle. diff = g_s ^ g_prev; popcount classifies 0 / 1 / >1 changed bits.
//  - Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2..0.
//  - FSM states:
//    FLUSH : counts SYNC_STAGES+1 cycles after reset so the chain and g_prev hold real
//            samples; -> PRIME.
//    PRIME : when diff == 0 (input stable for one cycle): out_binary <= decode(g_s),
//            out_valid <= 1, out_changed pulse; -> TRACK. Otherwise stay.
//    TRACK : diff == 0 -> hold, no pulse. Exactly 1 bit -> out_binary <= decode(g_s),
//            out_changed pulse. >1 bit -> out_binary held, err_multibit pulse,
//            err_count++ ; -> RESYNC.
//    RESYNC: out_valid stays 1, out_binary held. When diff == 0: load decode(g_s),
//            out_changed pulse; -> TRACK. Further >1-bit changes in RESYNC pulse
//            err_multibit and count again; 1-bit changes are ignored (held).
//  - Latency: a single-bit change on in_grey is reflected on out_binary and out_changed
//    SYNC_STAGES+1 clk cycles later (TRACK state).
//  - Wrap-around: grey all-ones-decoded max -> 0 (only the MSB differs) is a legal 1-bit
//    step; out_binary goes from 2^WIDTH-1 to 0 with out_changed, no error.
//  - err_count saturates at 16'hFFFF. clr_err has priority: clr_err with a simultaneous
//    rejection leaves err_count = 1; clr_err alone -> 0.
//  - out_changed and err_multibit are never high in the same cycle.
// TESTING
//  1. Reset, in_grey held 0 -> out_valid rises with out_binary=0 and one out_changed pulse
//     at cycle SYNC_STAGES+3 after reset release; no err_multibit.
//  2. Drive grey sequence for binary 0..1023, one step per 4 clk -> out_binary tracks
//     exactly, each update SYNC_STAGES+1 cycles after the input step; err_count stays 0.
//  3. WIDTH=8: in_grey 8'h80 (binary 255) -> 8'h00 -> out_binary 255 -> 0, out_changed,
//     no error.
//  4. In TRACK at grey 8'h05, jump to 8'h3A, hold -> one err_multibit, err_count=1,
//     out_binary held at 6 for one cycle, then loads 44 with out_changed.
//  5. Force 70000 rejections -> err_count=16'hFFFF; clr_err coincident with a rejection
//     -> err_count=1; clr_err alone -> 0.
//  6. Assert reset during RESYNC -> all outputs 0 next cycle, FSM re-primes as in test 1.

Source files
------------

// File: rtl/grey_to_binary_sync.sv
// grey_to_binary_sync
// Brings a grey-coded counter from a foreign clock domain into clk through a
// per-bit synchroniser. Samples where more than one bit moved between two
// consecutive synchronised values are rejected. Accepted samples are decoded
// to a monotonic binary count for the local timestamp compare logic.
`timescale 1ns/1ps

module grey_to_binary_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_grey,
  input  logic             clr_err,
  output logic [WIDTH-1:0] out_binary,
  output logic             out_valid,
  output logic             out_changed,
  output logic             err_multibit,
  output logic [15:0]      err_count
);

  // FLUSH lasts SYNC_STAGES+1 counted cycles plus the cycle that moves to PRIME
  localparam int CW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    FLUSH,
    PRIME,
    TRACK,
    RESYNC
  } state_t;

  state_t           state;
  logic [CW-1:0]    flush_cnt;
  logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
  logic [WIDTH-1:0] g_s;
  logic [WIDTH-1:0] g_prev;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] g_dec;
  logic             diff_zero;
  logic             diff_one;
  logic             diff_multi;
  logic             reject;

  assign g_s  = sync_chain[SYNC_STAGES-1];
  assign diff = g_s ^ g_prev;

  // A single set bit is a nonzero value whose lowest set bit is also its only one
  assign diff_zero  = (diff == '0);
  assign diff_one   = !diff_zero && ((diff & (diff - WIDTH'(1))) == '0);
  assign diff_multi = !diff_zero && !diff_one;

  // Multi-bit samples are only rejected once a baseline value has been accepted
  assign reject = diff_multi && ((state == TRACK) || (state == RESYNC));

  // Per-bit synchroniser chain, plus the previous synchronised sample for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= '0;
      end
      g_prev <= '0;
    end else begin
      sync_chain[0] <= in_grey;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
      g_prev <= g_s;
    end
  end

  // Grey decode: each binary bit is the XOR of all grey bits at or above it
  always_comb begin
    g_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g_dec[i] = ^(g_s >> i);
    end
  end

  // Control FSM with registered outputs and the saturating rejection counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FLUSH;
      flush_cnt    <= '0;
      out_binary   <= '0;
      out_valid    <= 1'b0;
      out_changed  <= 1'b0;
      err_multibit <= 1'b0;
      err_count    <= '0;
    end else begin
      out_changed  <= 1'b0;
      err_multibit <= reject;

      if (clr_err) begin
        err_count <= reject ? 16'd1 : 16'd0;
      end else if (reject && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end

      case (state)
        FLUSH: begin
          if (flush_cnt == CW'(SYNC_STAGES + 1)) begin
            state <= PRIME;
          end else begin
            flush_cnt <= flush_cnt + CW'(1);
          end
        end
        PRIME: begin
          if (diff_zero) begin
            out_binary  <= g_dec;
            out_valid   <= 1'b1;
            out_changed <= 1'b1;
            state       <= TRACK;
          end
        end
        TRACK: begin
          if (diff_one) begin
            out_binary  <= g_dec;
            out_changed <= 1'b1;
          end else if (diff_multi) begin
            state <= RESYNC;
          end
        end
        RESYNC: begin
          if (diff_zero) begin
            out_binary  <= g_dec;
            out_changed <= 1'b1;
            state       <= TRACK;
          end
        end
        default: begin
          state <= FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grey_to_binary_sync.sv
// tb_grey_to_binary_sync
// Directed stimulus for the grey-to-binary synchroniser at WIDTH=8 with a
// behavioural model of the expected outputs checked every cycle, plus
// hand-computed expectations at the points of interest.
`timescale 1ns/1ps

module tb_grey_to_binary_sync;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr_err;
  logic [WIDTH-1:0] in_grey;
  logic [WIDTH-1:0] out_binary;
  logic             out_valid;
  logic             out_changed;
  logic             err_multibit;
  logic [15:0]      err_count;

  int checks = 0;
  int errors = 0;

  grey_to_binary_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_grey      (in_grey),
    .clr_err      (clr_err),
    .out_binary   (out_binary),
    .out_valid    (out_valid),
    .out_changed  (out_changed),
    .err_multibit (err_multibit),
    .err_count    (err_count)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] toGrey(input int unsigned value);
    logic [WIDTH-1:0] b;
    b = WIDTH'(value);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] fromGrey(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs now, then advance the given number of rising edges and land 1 ns past the last
  task automatic applyStimulus(input logic [WIDTH-1:0] grey, input logic clr, input int cycles);
    in_grey = grey;
    clr_err = clr;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Model state: sampled input history (newest first), edges since reset, and expected outputs
  logic [WIDTH-1:0] hist[$];
  int               m_edges;
  bit               m_seen = 1'b0;
  bit               m_valid;
  bit               m_resync;
  bit               m_changed;
  bit               m_err;
  logic [15:0]      m_cnt;
  logic [WIDTH-1:0] m_bin;

  // Behavioural model: the value seen SYNC_STAGES edges ago is compared with the one before it
  always @(posedge clk) begin
    logic [WIDTH-1:0] gs;
    logic [WIDTH-1:0] gp;
    int               nbits;
    if (reset) begin
      hist.delete();
      for (int i = 0; i <= SYNC_STAGES; i++) hist.push_back('0);
      m_edges   = 0;
      m_valid   = 1'b0;
      m_resync  = 1'b0;
      m_changed = 1'b0;
      m_err     = 1'b0;
      m_cnt     = '0;
      m_bin     = '0;
      m_seen    = 1'b1;
    end else if (m_seen) begin
      gs        = hist[SYNC_STAGES-1];
      gp        = hist[SYNC_STAGES];
      nbits     = $countones(gs ^ gp);
      m_changed = 1'b0;
      m_err     = 1'b0;
      if (m_edges < SYNC_STAGES + 2) begin
        m_edges++;
      end else if (!m_valid) begin
        if (nbits == 0) begin
          m_bin     = fromGrey(gs);
          m_valid   = 1'b1;
          m_changed = 1'b1;
        end
      end else if (!m_resync) begin
        if (nbits == 1) begin
          m_bin     = fromGrey(gs);
          m_changed = 1'b1;
        end else if (nbits > 1) begin
          m_err    = 1'b1;
          m_resync = 1'b1;
        end
      end else begin
        if (nbits == 0) begin
          m_bin     = fromGrey(gs);
          m_changed = 1'b1;
          m_resync  = 1'b0;
        end else if (nbits > 1) begin
          m_err = 1'b1;
        end
      end
      if (clr_err) m_cnt = m_err ? 16'd1 : 16'd0;
      else if (m_err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      hist.push_front(in_grey);
      void'(hist.pop_back());
    end
  end

  // Every cycle after the first reset the DUT must agree with the model
  always @(negedge clk) begin
    if (m_seen) begin
      checkOutput("model_binary",  32'(out_binary),   32'(m_bin));
      checkOutput("model_valid",   32'(out_valid),    32'(m_valid));
      checkOutput("model_changed", 32'(out_changed),  32'(m_changed));
      checkOutput("model_err",     32'(err_multibit), 32'(m_err));
      checkOutput("model_count",   32'(err_count),    32'(m_cnt));
      checkOutput("pulse_exclusive", 32'(out_changed & err_multibit), 32'd0);
    end
  end

  // Directed sequence: priming, counting, wrap, multibit reject, saturation, reset in RESYNC
  initial begin
    reset   = 1'b1;
    in_grey = '0;
    clr_err = 1'b0;
    applyStimulus('0, 1'b0, 3);
    reset = 1'b0;

    // Priming after reset with input held at zero
    applyStimulus('0, 1'b0, SYNC_STAGES + 2);
    checkOutput("t1_valid_early", 32'(out_valid), 32'd0);
    checkOutput("t1_changed_early", 32'(out_changed), 32'd0);
    applyStimulus('0, 1'b0, 1);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_changed", 32'(out_changed), 32'd1);
    checkOutput("t1_binary", 32'(out_binary), 32'd0);
    checkOutput("t1_err", 32'(err_multibit), 32'd0);
    applyStimulus('0, 1'b0, 1);
    checkOutput("t1_changed_once", 32'(out_changed), 32'd0);

    // Counting sequence; first step pins the latency
    applyStimulus(8'h01, 1'b0, SYNC_STAGES);
    checkOutput("t2_latency_hold", 32'(out_binary), 32'd0);
    checkOutput("t2_latency_nopulse", 32'(out_changed), 32'd0);
    applyStimulus(8'h01, 1'b0, 1);
    checkOutput("t2_latency_binary", 32'(out_binary), 32'd1);
    checkOutput("t2_latency_pulse", 32'(out_changed), 32'd1);
    applyStimulus(8'h01, 1'b0, 1);
    for (int n = 2; n < 1024; n++) begin
      applyStimulus(toGrey(n), 1'b0, 4);
    end
    checkOutput("t2_final_binary", 32'(out_binary), 32'd255);
    checkOutput("t2_err_count", 32'(err_count), 32'd0);

    // Wrap-around from grey 80 (255) to grey 00 (0)
    applyStimulus(8'h00, 1'b0, SYNC_STAGES);
    checkOutput("t3_before_wrap", 32'(out_binary), 32'd255);
    applyStimulus(8'h00, 1'b0, 1);
    checkOutput("t3_wrap_binary", 32'(out_binary), 32'd0);
    checkOutput("t3_wrap_changed", 32'(out_changed), 32'd1);
    checkOutput("t3_wrap_err", 32'(err_multibit), 32'd0);
    applyStimulus(8'h00, 1'b0, 2);

    // Walk to grey 05 (binary 6), then jump to grey 3A (binary 44)
    for (int v = 1; v <= 6; v++) begin
      applyStimulus(toGrey(v), 1'b0, 4);
    end
    checkOutput("t4_start_binary", 32'(out_binary), 32'd6);
    applyStimulus(8'h3A, 1'b0, SYNC_STAGES + 1);
    checkOutput("t4_err_pulse", 32'(err_multibit), 32'd1);
    checkOutput("t4_held_binary", 32'(out_binary), 32'd6);
    checkOutput("t4_err_count", 32'(err_count), 32'd1);
    checkOutput("t4_no_change", 32'(out_changed), 32'd0);
    applyStimulus(8'h3A, 1'b0, 1);
    checkOutput("t4_resync_binary", 32'(out_binary), 32'd44);
    checkOutput("t4_resync_changed", 32'(out_changed), 32'd1);
    applyStimulus(8'h3A, 1'b0, 2);

    // Saturate the rejection counter by toggling two bits every cycle
    for (int i = 0; i < 65600; i++) begin
      applyStimulus((i % 2 == 1) ? 8'h39 : 8'h3A, 1'b0, 1);
    end
    checkOutput("t5_saturated", 32'(err_count), 32'hFFFF);
    applyStimulus(8'h3A, 1'b1, 1);
    checkOutput("t5_clr_with_reject", 32'(err_count), 32'd1);
    applyStimulus(8'h3A, 1'b0, SYNC_STAGES + 3);
    applyStimulus(8'h3A, 1'b1, 1);
    checkOutput("t5_clr_alone", 32'(err_count), 32'd0);
    applyStimulus(8'h3A, 1'b0, 2);

    // Reset while in RESYNC
    applyStimulus(8'h35, 1'b0, SYNC_STAGES + 1);
    checkOutput("t6_in_resync", 32'(err_multibit), 32'd1);
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1);
    checkOutput("t6_rst_binary", 32'(out_binary), 32'd0);
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_changed", 32'(out_changed), 32'd0);
    checkOutput("t6_rst_err", 32'(err_multibit), 32'd0);
    checkOutput("t6_rst_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    applyStimulus('0, 1'b0, SYNC_STAGES + 2);
    checkOutput("t6_valid_early", 32'(out_valid), 32'd0);
    applyStimulus('0, 1'b0, 1);
    checkOutput("t6_valid", 32'(out_valid), 32'd1);
    checkOutput("t6_changed", 32'(out_changed), 32'd1);
    checkOutput("t6_binary", 32'(out_binary), 32'd0);
    applyStimulus('0, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
